// File: rtl/fpu_cvt_f2i_pipe.sv
// rtl/fpu_cvt_f2i_pipe.sv - 3-stage float-to-integer converter; FPU_CVT_FLAGS_EN adds {NV,NX} out_flags
module fpu_cvt_f2i_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int OUT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_f,
  input  logic [2:0]             in_rm,
  input  logic                   in_uns,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_int
`ifdef FPU_CVT_FLAGS_EN
  ,
  output logic [1:0]             out_flags
`endif
);

  localparam int FW   = 1 + EXP_W + MAN_W;
  localparam int IW   = OUT_W + 1;          // integer part wide enough for e == OUT_W
  localparam int FXW  = IW + MAN_W;         // fixed point: IW integer bits, MAN_W fraction bits
  localparam int SHW  = $clog2(OUT_W + 1);
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;

  localparam logic [OUT_W+1:0] LIM_SP = {3'b000, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W+1:0] LIM_SN = {3'b001, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W+1:0] LIM_U  = {2'b00, {OUT_W{1'b1}}};
  localparam logic [OUT_W-1:0] SMAX   = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SMIN   = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] UMAX   = {OUT_W{1'b1}};

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // stage 1 classify
  logic               sign_c, exp_ones, exp_zero, normal_c;
  logic [EXP_W-1:0]   exp_c;
  logic [MAN_W-1:0]   man_c;
  logic signed [31:0] e_c;

  assign sign_c   = in_f[FW-1];
  assign exp_c    = in_f[FW-2:MAN_W];
  assign man_c    = in_f[MAN_W-1:0];
  assign exp_ones = &exp_c;
  assign exp_zero = ~|exp_c;
  assign normal_c = !exp_ones && !exp_zero;
  assign e_c      = $signed({{(32-EXP_W){1'b0}}, exp_c}) - BIAS;

  logic             s1_valid, s1_sign, s1_nan, s1_big, s1_tiny, s1_half, s1_uns;
  logic [SHW-1:0]   s1_sh;
  logic [MAN_W:0]   s1_mant;
  logic [2:0]       s1_rm;

  // S1: unpack operand; big = inf/NaN/out of shifter range, tiny = below 1.0 but nonzero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_nan   <= 1'b0;
      s1_big   <= 1'b0;
      s1_tiny  <= 1'b0;
      s1_half  <= 1'b0;
      s1_uns   <= 1'b0;
      s1_sh    <= '0;
      s1_mant  <= '0;
      s1_rm    <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_sign  <= sign_c;
      s1_nan   <= exp_ones && (|man_c);
      s1_big   <= exp_ones || (normal_c && (e_c > OUT_W));
      s1_tiny  <= (exp_zero && (|man_c)) || (normal_c && (e_c < 0));
      s1_half  <= normal_c && (e_c == -1);
      s1_sh    <= (normal_c && (e_c >= 0) && (e_c <= OUT_W)) ? e_c[SHW-1:0] : '0;
      s1_mant  <= {normal_c, man_c};
      s1_rm    <= in_rm;
      s1_uns   <= in_uns;
    end
  end

  // stage 2 align; zero falls through the shifter with mant=0, sh=0
  logic [FXW-1:0] fx_c;
  assign fx_c = {{(IW-1){1'b0}}, s1_mant} << s1_sh;

  logic             s2_valid, s2_sign, s2_nan, s2_big, s2_g, s2_s, s2_uns;
  logic [IW-1:0]    s2_mag;
  logic [2:0]       s2_rm;

  // S2: integer magnitude plus guard/sticky; big and tiny operands bypass the shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_nan   <= 1'b0;
      s2_big   <= 1'b0;
      s2_g     <= 1'b0;
      s2_s     <= 1'b0;
      s2_uns   <= 1'b0;
      s2_mag   <= '0;
      s2_rm    <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_nan   <= s1_nan;
      s2_big   <= s1_big;
      s2_uns   <= s1_uns;
      s2_rm    <= s1_rm;
      if (s1_big || s1_tiny) begin
        s2_mag <= '0;
        s2_g   <= !s1_big && s1_half;
        s2_s   <= !s1_big && (!s1_half || (|s1_mant[MAN_W-1:0]));
      end else begin
        s2_mag <= fx_c[FXW-1:MAN_W];
        s2_g   <= fx_c[MAN_W-1];
        s2_s   <= |fx_c[MAN_W-2:0];
      end
    end
  end

  // stage 3 round, range check, saturate
  logic             inc_c, nv_c;
  logic [OUT_W+1:0] rmag_c;
  logic [OUT_W-1:0] sat_c, res_c;

  // rounding increment decision; unknown rm codes round to nearest-even
  always_comb begin
    case (s2_rm)
      3'b001:  inc_c = 1'b0;
      3'b010:  inc_c = s2_sign && (s2_g || s2_s);
      3'b011:  inc_c = !s2_sign && (s2_g || s2_s);
      3'b100:  inc_c = s2_g;
      default: inc_c = s2_g && (s2_s || s2_mag[0]);
    endcase
  end

  assign rmag_c = {1'b0, s2_mag} + {{(OUT_W+1){1'b0}}, inc_c};

  // post-rounding range check selects saturation value or signed/unsigned result
  always_comb begin
    nv_c  = 1'b0;
    sat_c = '0;
    if (s2_nan) begin
      nv_c  = 1'b1;
      sat_c = s2_uns ? UMAX : SMAX;
    end else if (s2_big) begin
      nv_c  = 1'b1;
      sat_c = s2_sign ? (s2_uns ? '0 : SMIN) : (s2_uns ? UMAX : SMAX);
    end else if (s2_uns) begin
      if (s2_sign && (rmag_c != '0)) begin
        nv_c  = 1'b1;
        sat_c = '0;
      end else if (!s2_sign && (rmag_c > LIM_U)) begin
        nv_c  = 1'b1;
        sat_c = UMAX;
      end
    end else begin
      if (!s2_sign && (rmag_c > LIM_SP)) begin
        nv_c  = 1'b1;
        sat_c = SMAX;
      end else if (s2_sign && (rmag_c > LIM_SN)) begin
        nv_c  = 1'b1;
        sat_c = SMIN;
      end
    end
    res_c = nv_c ? sat_c
                 : ((s2_sign && !s2_uns) ? -rmag_c[OUT_W-1:0] : rmag_c[OUT_W-1:0]);
  end

  // output register, held while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_int   <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      out_int   <= res_c;
    end
  end

`ifdef FPU_CVT_FLAGS_EN
  logic nx_c;
  assign nx_c = !nv_c && (s2_g || s2_s);

  // exception flags travel with the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_flags <= 2'b00;
    end else if (adv) begin
      out_flags <= {nv_c, nx_c};
    end
  end
`endif

endmodule

// File: tb/tb_fpu_cvt_f2i_pipe.sv
// tb/tb_fpu_cvt_f2i_pipe.sv - scoreboard bench for fpu_cvt_f2i_pipe (flag checks when FPU_CVT_FLAGS_EN)
module tb_fpu_cvt_f2i_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_f = '0;
  logic [2:0]  in_rm = '0;
  logic        in_uns = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_int;
`ifdef FPU_CVT_FLAGS_EN
  logic [1:0]  out_flags;
`endif

  always #5 clk = ~clk;

  fpu_cvt_f2i_pipe #(.EXP_W(8), .MAN_W(23), .OUT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_f      (in_f),
    .in_rm     (in_rm),
    .in_uns    (in_uns),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_int   (out_int)
`ifdef FPU_CVT_FLAGS_EN
    ,
    .out_flags (out_flags)
`endif
  );

  typedef struct packed {
    logic [31:0] f;
    logic [31:0] val;
    logic [1:0]  fl;
  } exp_t;

  typedef struct packed {
    logic [31:0] f;
    logic [2:0]  rm;
    logic        uns;
    logic [31:0] val;
    logic [1:0]  fl;
  } tv_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic send(input logic [31:0] f, input logic [2:0] rm, input logic uns,
                      input logic [31:0] val, input logic [1:0] fl);
    exp_t e;
    bit   took;
    @(negedge clk);
    in_valid = 1'b1;
    in_f     = f;
    in_rm    = rm;
    in_uns   = uns;
    took     = 1'b0;
    for (int i = 0; i < 50 && !took; i++) begin
      #4;
      took = in_ready;
      @(posedge clk);
      if (!took) @(negedge clk);
    end
    if (took) begin
      e.f = f; e.val = val; e.fl = fl;
      sb.push_back(e);
    end else begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout f=%h in_ready=0 required=1", f);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++;
    if (out_int !== 32'h0) begin n_bad++; $display("FAIL reset_out_int got=%h want=0", out_int); end
`ifdef FPU_CVT_FLAGS_EN
    n_cmp++;
    if (out_flags !== 2'b00) begin n_bad++; $display("FAIL reset_out_flags got=%b want=00", out_flags); end
`endif
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_latency;
    int   lat;
    exp_t e;
    lat = 0;
    send(32'h40490FDB, 3'd0, 1'b0, 32'h00000003, 2'b01);
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) lat = i;
    end
    n_cmp++;
    if (lat !== 3) begin n_bad++; $display("FAIL latency got=%0d want=3", lat); end
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    n_cmp++;
    if (out_int !== e.val) begin n_bad++; $display("FAIL pi_value got=%h want=%h", out_int, e.val); end
`ifdef FPU_CVT_FLAGS_EN
    n_cmp++;
    if (out_flags !== e.fl) begin n_bad++; $display("FAIL pi_flags got=%b want=%b", out_flags, e.fl); end
`endif
  endtask

  task automatic test_rounding;
    tv_t  tbl [17];
    exp_t e;
    bit   got;
    tbl = '{
      {32'h3FC00000, 3'd0, 1'b0, 32'h00000002, 2'b01},
      {32'h3FC00000, 3'd1, 1'b0, 32'h00000001, 2'b01},
      {32'h3FC00000, 3'd2, 1'b0, 32'h00000001, 2'b01},
      {32'h3FC00000, 3'd3, 1'b0, 32'h00000002, 2'b01},
      {32'hBFC00000, 3'd0, 1'b0, 32'hFFFFFFFE, 2'b01},
      {32'hBFC00000, 3'd3, 1'b0, 32'hFFFFFFFF, 2'b01},
      {32'hBFC00000, 3'd4, 1'b0, 32'hFFFFFFFE, 2'b01},
      {32'hBFC00000, 3'd2, 1'b0, 32'hFFFFFFFE, 2'b01},
      {32'h40200000, 3'd0, 1'b0, 32'h00000002, 2'b01},
      {32'h40200000, 3'd4, 1'b0, 32'h00000003, 2'b01},
      {32'h3F000000, 3'd0, 1'b0, 32'h00000000, 2'b01},
      {32'h80000000, 3'd0, 1'b0, 32'h00000000, 2'b00},
      {32'h40200000, 3'd7, 1'b0, 32'h00000002, 2'b01},
      {32'h3F400000, 3'd0, 1'b0, 32'h00000001, 2'b01},
      {32'h00000001, 3'd3, 1'b0, 32'h00000001, 2'b01},
      {32'h80000001, 3'd2, 1'b0, 32'hFFFFFFFF, 2'b01},
      {32'h41200000, 3'd1, 1'b0, 32'h0000000A, 2'b00}
    };
    foreach (tbl[k]) begin
      send(tbl[k].f, tbl[k].rm, tbl[k].uns, tbl[k].val, tbl[k].fl);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        in_valid = 1'b0;
        got = out_valid;
      end
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      n_cmp++;
      if (!got || out_int !== e.val) begin
        n_bad++;
        $display("FAIL rnd_value f=%h rm=%0d got=%h valid=%b want=%h", tbl[k].f, tbl[k].rm, out_int, got, e.val);
      end
`ifdef FPU_CVT_FLAGS_EN
      n_cmp++;
      if (out_flags !== e.fl) begin
        n_bad++;
        $display("FAIL rnd_flags f=%h rm=%0d got=%b want=%b", tbl[k].f, tbl[k].rm, out_flags, e.fl);
      end
`endif
    end
  endtask

  task automatic test_saturation;
    tv_t  tbl [18];
    exp_t e;
    bit   got;
    tbl = '{
      {32'h4F000000, 3'd0, 1'b0, 32'h7FFFFFFF, 2'b10},
      {32'hCF000000, 3'd0, 1'b0, 32'h80000000, 2'b00},
      {32'h7FC00000, 3'd0, 1'b0, 32'h7FFFFFFF, 2'b10},
      {32'h4F000000, 3'd0, 1'b1, 32'h80000000, 2'b00},
      {32'h7FC00000, 3'd0, 1'b1, 32'hFFFFFFFF, 2'b10},
      {32'hBF800000, 3'd0, 1'b1, 32'h00000000, 2'b10},
      {32'hBE800000, 3'd1, 1'b1, 32'h00000000, 2'b01},
      {32'h7F800000, 3'd0, 1'b0, 32'h7FFFFFFF, 2'b10},
      {32'hFF800000, 3'd0, 1'b0, 32'h80000000, 2'b10},
      {32'hFF800000, 3'd0, 1'b1, 32'h00000000, 2'b10},
      {32'h4F800000, 3'd0, 1'b1, 32'hFFFFFFFF, 2'b10},
      {32'h4F7FFFFF, 3'd0, 1'b1, 32'hFFFFFF00, 2'b00},
      {32'hCF000001, 3'd0, 1'b0, 32'h80000000, 2'b10},
      {32'h5F000000, 3'd0, 1'b0, 32'h7FFFFFFF, 2'b10},
      {32'hBF000000, 3'd0, 1'b1, 32'h00000000, 2'b01},
      {32'hBF400000, 3'd0, 1'b1, 32'h00000000, 2'b10},
      {32'hFFC00000, 3'd0, 1'b0, 32'h7FFFFFFF, 2'b10},
      {32'h4EFFFFFF, 3'd3, 1'b0, 32'h7FFFFF80, 2'b00}
    };
    foreach (tbl[k]) begin
      send(tbl[k].f, tbl[k].rm, tbl[k].uns, tbl[k].val, tbl[k].fl);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        in_valid = 1'b0;
        got = out_valid;
      end
      e = (sb.size() > 0) ? sb.pop_front() : '0;
      n_cmp++;
      if (!got || out_int !== e.val) begin
        n_bad++;
        $display("FAIL sat_value f=%h uns=%b got=%h valid=%b want=%h", tbl[k].f, tbl[k].uns, out_int, got, e.val);
      end
`ifdef FPU_CVT_FLAGS_EN
      n_cmp++;
      if (out_flags !== e.fl) begin
        n_bad++;
        $display("FAIL sat_flags f=%h uns=%b got=%b want=%b", tbl[k].f, tbl[k].uns, out_flags, e.fl);
      end
`endif
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] held;
    exp_t        e;
    int          rcv;
    int          extra;
    bit          stall;
    rcv = 0; extra = 0; held = '0;
    fork
      begin
        send(32'h3F800000, 3'd0, 1'b0, 32'h00000001, 2'b00);
        send(32'h40000000, 3'd0, 1'b0, 32'h00000002, 2'b00);
        send(32'h40400000, 3'd0, 1'b0, 32'h00000003, 2'b00);
        send(32'hC0E00000, 3'd0, 1'b0, 32'hFFFFFFF9, 2'b00);
        send(32'h42C80000, 3'd0, 1'b0, 32'h00000064, 2'b00);
        send(32'h40C00000, 3'd0, 1'b0, 32'h00000006, 2'b00);
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 80 && rcv < 6; c++) begin
          @(negedge clk);
          stall = (c >= 4) && (c < 9);
          if (c == 4) begin
            held = out_int;
            n_cmp++;
            if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_stall_start valid got=%b want=1", out_valid); end
          end
          if (stall && c > 4) begin
            n_cmp++;
            if (out_int !== held || out_valid !== 1'b1) begin
              n_bad++;
              $display("FAIL b2b_hold c=%0d got=%h/%b want=%h/1", c, out_int, out_valid, held);
            end
            n_cmp++;
            if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_in_ready c=%0d got=%b want=0", c, in_ready); end
          end
          out_ready = !stall;
          if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
              extra++;
            end else begin
              e = sb.pop_front();
              rcv++;
              n_cmp++;
              if (out_int !== e.val) begin
                n_bad++;
                $display("FAIL b2b_value idx=%0d got=%h want=%h", rcv, out_int, e.val);
              end
            end
          end
        end
      end
    join
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    n_cmp++;
    if (rcv !== 6) begin n_bad++; $display("FAIL b2b_count got=%0d want=6", rcv); end
    n_cmp++;
    if (extra !== 0) begin n_bad++; $display("FAIL b2b_duplicates got=%0d want=0", extra); end
  endtask

  task automatic test_reset_inflight;
    int stale;
    out_ready = 1'b1;
    send(32'h3F800000, 3'd0, 1'b0, 32'h00000001, 2'b00);
    send(32'h40000000, 3'd0, 1'b0, 32'h00000002, 2'b00);
    send(32'h40400000, 3'd0, 1'b0, 32'h00000003, 2'b00);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_pre_valid got=%b want=1", out_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_int !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_inflight got=%b/%h want=0/0", out_valid, out_int);
    end
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    n_cmp++;
    if (stale !== 0) begin n_bad++; $display("FAIL rst_stale got=%0d want=0", stale); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
